mip_port_arbiter: RTL
=====================

MIP_PORT_ARBITER -- requirements
Module: mip_port_arbiter

Interface
REQ-001 SHALL have parameter RD_LAT, default 2, meaning VRAM read latency in cycles from the ena cycle to valid douta (legal range 1..7).
REQ-002 SHALL have parameter NUM_WORDS, default 38400, meaning VRAM words cleared, equal to 480 rows x 80 words.
REQ-003 SHALL have port clock  in  1  meaning the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset  in  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port io_en  in  1  meaning enable acceptance of new calc results.
REQ-006 SHALL have port io_clear  in  1  meaning a one-cycle pulse requesting a zero-fill of the VRAM.
REQ-007 SHALL have port io_busy  out  1  meaning a clear is pending or in progress.
REQ-008 SHALL have, for N=0..3, ports io_calc_res_N_data_valid  in  1  (FWFT FIFO non-empty), io_calc_res_N_rden  out  1  (pop), io_calc_res_N_screen_pos_x  in  10, io_calc_res_N_screen_pos_y  in  10 and io_calc_res_N_density  in  8.
REQ-009 SHALL have ports io_ram_port_addra  out  64, io_ram_port_dina  out  64, io_ram_port_douta  in  64, io_ram_port_ena  out  1 and io_ram_port_wea  out  8 (per-byte write enable).

Function
REQ-010 SHALL implement FSM states IDLE, READ, WAIT, CMP, WRITE and CLEAR.
REQ-011 SHALL, in IDLE when io_en=1, no clear is pending and any data_valid=1, grant one channel by round-robin, with priority starting at (last_grant+1) mod 4.
REQ-012 SHALL, in the grant cycle, assert the granted rden for exactly 1 cycle, latch x, y and density, update last_grant and go to READ.
REQ-013 SHALL compute word address = y*80 + x[9:3] (y*80 as (y<<6)+(y<<4)), zero-extended to 64 bits, with byte lane = x[2:0].
REQ-014 SHALL, for a latched x>=640 or y>=480, pop the entry and issue no RAM access, returning to IDLE the next cycle.
REQ-015 SHALL, in READ (1 cycle), drive ena=1, wea=0 and addra=word address.
REQ-016 SHALL hold WAIT for RD_LAT-1 cycles, skipping it when RD_LAT=1, with ena=0.
REQ-017 SHALL, in CMP, sample douta byte[lane]; if density > stored go to WRITE, else go to IDLE, keeping the stored maximum (max-intensity projection).
REQ-018 SHALL, in WRITE (1 cycle), drive ena=1, wea=1<<lane, dina = density replicated in all 8 bytes and the same addra, then go to IDLE.
REQ-019 SHALL achieve grant-to-grant latency, with RD_LAT=2, of 4 cycles with no write and 5 cycles with a write; only one transaction SHALL be in flight, so no RMW hazard exists.
REQ-020 SHALL latch an io_clear pulse seen in any state into clear_pending and set io_busy=1 from the next cycle.
REQ-021 SHALL, in IDLE with clear_pending=1, enter CLEAR in preference to any channel, also when io_en=0.
REQ-022 SHALL, in CLEAR, write ena=1, wea=0xFF, dina=0 at addresses 0..NUM_WORDS-1 (one word per cycle, counter wraps back to 0), then clear clear_pending, drop io_busy and return to IDLE.
REQ-023 SHALL keep all rden=0 during CLEAR, and SHALL ignore a new io_clear during CLEAR, not re-queueing it.
REQ-024 SHALL, when io_en falls mid-transaction, complete that transaction and grant nothing further.
REQ-025 SHALL, when not in READ, WRITE or CLEAR, drive ena=0, wea=0, and addra/dina=0.

Reset
REQ-026 SHALL, on reset=0, immediately set state=IDLE, last_grant=3 (so channel 0 has priority first), clear_pending=0, clear counter=0, and all rden, ena, wea, io_busy=0 with addra/dina=0.
REQ-027 SHALL, on reset asserted mid-transaction or mid-CLEAR, abandon the operation without completing the write or re-queueing.

Verification
REQ-028 Single hit: ch0 x=9,y=1,d=0x40, RAM word 81 = 0 -> rden0 1 cycle, READ addra=81, WRITE wea=0x02 with dina byte1=0x40.
REQ-029 No-update: stored byte 0x80, d=0x40 -> READ only, no WRITE, next grant 4 cycles after the previous one.
REQ-030 Round-robin: all 4 channels valid continuously -> grant order 0,1,2,3,0 and each rden pulses once per 4 grants.
REQ-031 Clear during a transaction: io_clear at the READ cycle -> transaction completes, io_busy=1, then NUM_WORDS writes of 0 at wea=0xFF, no rden, then io_busy=0.
REQ-032 Out of range: x=700 -> rden pulses, no ena, back to IDLE the next cycle.
REQ-033 Reset mid-WAIT -> all outputs 0 within the same cycle, next grant goes to ch0.

Source files
------------

// File: rtl/mip_port_arbiter_if.sv
// Bus bundle for the MIP port arbiter: control, four calc-result FIFO ports and the VRAM port.
interface mip_port_arbiter_if;
  logic        io_en;
  logic        io_clear;
  logic        io_busy;

  logic        io_calc_res_0_data_valid;
  logic        io_calc_res_0_rden;
  logic [9:0]  io_calc_res_0_screen_pos_x;
  logic [9:0]  io_calc_res_0_screen_pos_y;
  logic [7:0]  io_calc_res_0_density;

  logic        io_calc_res_1_data_valid;
  logic        io_calc_res_1_rden;
  logic [9:0]  io_calc_res_1_screen_pos_x;
  logic [9:0]  io_calc_res_1_screen_pos_y;
  logic [7:0]  io_calc_res_1_density;

  logic        io_calc_res_2_data_valid;
  logic        io_calc_res_2_rden;
  logic [9:0]  io_calc_res_2_screen_pos_x;
  logic [9:0]  io_calc_res_2_screen_pos_y;
  logic [7:0]  io_calc_res_2_density;

  logic        io_calc_res_3_data_valid;
  logic        io_calc_res_3_rden;
  logic [9:0]  io_calc_res_3_screen_pos_x;
  logic [9:0]  io_calc_res_3_screen_pos_y;
  logic [7:0]  io_calc_res_3_density;

  logic [63:0] io_ram_port_addra;
  logic [63:0] io_ram_port_dina;
  logic [63:0] io_ram_port_douta;
  logic        io_ram_port_ena;
  logic [7:0]  io_ram_port_wea;

  // Arbiter side.
  modport master (
    input  io_en, io_clear, io_ram_port_douta,
    input  io_calc_res_0_data_valid, io_calc_res_0_screen_pos_x, io_calc_res_0_screen_pos_y,
    input  io_calc_res_0_density,
    input  io_calc_res_1_data_valid, io_calc_res_1_screen_pos_x, io_calc_res_1_screen_pos_y,
    input  io_calc_res_1_density,
    input  io_calc_res_2_data_valid, io_calc_res_2_screen_pos_x, io_calc_res_2_screen_pos_y,
    input  io_calc_res_2_density,
    input  io_calc_res_3_data_valid, io_calc_res_3_screen_pos_x, io_calc_res_3_screen_pos_y,
    input  io_calc_res_3_density,
    output io_busy, io_ram_port_addra, io_ram_port_dina, io_ram_port_ena, io_ram_port_wea,
    output io_calc_res_0_rden, io_calc_res_1_rden, io_calc_res_2_rden, io_calc_res_3_rden
  );

  // FIFO / VRAM / controller side.
  modport slave (
    output io_en, io_clear, io_ram_port_douta,
    output io_calc_res_0_data_valid, io_calc_res_0_screen_pos_x, io_calc_res_0_screen_pos_y,
    output io_calc_res_0_density,
    output io_calc_res_1_data_valid, io_calc_res_1_screen_pos_x, io_calc_res_1_screen_pos_y,
    output io_calc_res_1_density,
    output io_calc_res_2_data_valid, io_calc_res_2_screen_pos_x, io_calc_res_2_screen_pos_y,
    output io_calc_res_2_density,
    output io_calc_res_3_data_valid, io_calc_res_3_screen_pos_x, io_calc_res_3_screen_pos_y,
    output io_calc_res_3_density,
    input  io_busy, io_ram_port_addra, io_ram_port_dina, io_ram_port_ena, io_ram_port_wea,
    input  io_calc_res_0_rden, io_calc_res_1_rden, io_calc_res_2_rden, io_calc_res_3_rden
  );
endinterface

// File: rtl/mip_port_arbiter.sv
// Round-robin arbiter of four calc-result FIFOs into a VRAM doing max-intensity projection
// (read byte, keep the larger density), plus a full-VRAM zero-fill on request.
module mip_port_arbiter #(
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned NUM_WORDS = 38400
) (
  input logic                 clock,
  input logic                 reset,
  mip_port_arbiter_if.master  bus
);

  localparam int unsigned CntW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [2:0] {StIdle, StRead, StWait, StCmp, StWrite, StClear} state_e;

  state_e            state_q, state_d;
  logic [1:0]        last_q, last_d;
  logic              clear_pending_q, clear_pending_d;
  logic [CntW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [2:0]        wait_q, wait_d;
  logic [9:0]        x_q, y_q;
  logic [7:0]        dens_q;
  logic              rdy_q;

  logic [3:0]        valid, rden;
  logic [9:0]        pos_x [4];
  logic [9:0]        pos_y [4];
  logic [7:0]        dens [4];
  logic [1:0]        grant, idx;
  logic              found, latch;
  logic [16:0]       word_addr;
  logic              oor;
  logic [7:0]        stored;

  assign valid = {bus.io_calc_res_3_data_valid, bus.io_calc_res_2_data_valid,
                  bus.io_calc_res_1_data_valid, bus.io_calc_res_0_data_valid};
  assign pos_x[0] = bus.io_calc_res_0_screen_pos_x;
  assign pos_x[1] = bus.io_calc_res_1_screen_pos_x;
  assign pos_x[2] = bus.io_calc_res_2_screen_pos_x;
  assign pos_x[3] = bus.io_calc_res_3_screen_pos_x;
  assign pos_y[0] = bus.io_calc_res_0_screen_pos_y;
  assign pos_y[1] = bus.io_calc_res_1_screen_pos_y;
  assign pos_y[2] = bus.io_calc_res_2_screen_pos_y;
  assign pos_y[3] = bus.io_calc_res_3_screen_pos_y;
  assign dens[0]  = bus.io_calc_res_0_density;
  assign dens[1]  = bus.io_calc_res_1_density;
  assign dens[2]  = bus.io_calc_res_2_density;
  assign dens[3]  = bus.io_calc_res_3_density;

  assign bus.io_calc_res_0_rden = rden[0];
  assign bus.io_calc_res_1_rden = rden[1];
  assign bus.io_calc_res_2_rden = rden[2];
  assign bus.io_calc_res_3_rden = rden[3];
  assign bus.io_busy = clear_pending_q;

  // y*80 + x/8 built from shifts; 17 bits so out-of-range y cannot wrap.
  assign word_addr = ({7'd0, y_q} << 6) + ({7'd0, y_q} << 4) + {10'd0, x_q[9:3]};
  assign oor       = (x_q >= 10'd640) || (y_q >= 10'd480);
  assign stored    = bus.io_ram_port_douta[{x_q[2:0], 3'b000} +: 8];

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= StIdle;
      last_q          <= 2'd3;
      clear_pending_q <= 1'b0;
      clr_cnt_q       <= '0;
      wait_q          <= '0;
      x_q             <= '0;
      y_q             <= '0;
      dens_q          <= '0;
      rdy_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_q          <= last_d;
      clear_pending_q <= clear_pending_d;
      clr_cnt_q       <= clr_cnt_d;
      wait_q          <= wait_d;
      rdy_q           <= 1'b1;
      if (latch) begin
        x_q    <= pos_x[grant];
        y_q    <= pos_y[grant];
        dens_q <= dens[grant];
      end
    end
  end

  // Next state, grant selection and VRAM port drive.
  always_comb begin
    state_d         = state_q;
    last_d          = last_q;
    clr_cnt_d       = clr_cnt_q;
    wait_d          = wait_q;
    // A clear arriving while already clearing is dropped, not queued.
    clear_pending_d = clear_pending_q | (bus.io_clear && (state_q != StClear));
    grant           = '0;
    idx             = '0;
    found           = 1'b0;
    latch           = 1'b0;
    rden            = '0;
    bus.io_ram_port_ena   = 1'b0;
    bus.io_ram_port_wea   = '0;
    bus.io_ram_port_addra = '0;
    bus.io_ram_port_dina  = '0;

    unique case (state_q)
      StIdle: begin
        if (clear_pending_q) begin
          state_d = StClear;
        end else if (bus.io_en && rdy_q && (valid != 4'b0)) begin
          for (int i = 0; i < 4; i++) begin
            idx = last_q + 2'(i + 1);
            if (!found && valid[idx]) begin
              found = 1'b1;
              grant = idx;
            end
          end
          rden[grant] = 1'b1;
          last_d      = grant;
          latch       = 1'b1;
          state_d     = StRead;
        end
      end
      StRead: begin
        if (oor) begin
          state_d = StIdle;
        end else begin
          bus.io_ram_port_ena   = 1'b1;
          bus.io_ram_port_addra = 64'(word_addr);
          wait_d                = '0;
          state_d               = (RD_LAT == 1) ? StCmp : StWait;
        end
      end
      StWait: begin
        if (wait_q == 3'(RD_LAT - 2)) state_d = StCmp;
        else                          wait_d  = wait_q + 3'd1;
      end
      StCmp: begin
        state_d = (dens_q > stored) ? StWrite : StIdle;
      end
      StWrite: begin
        bus.io_ram_port_ena   = 1'b1;
        bus.io_ram_port_wea   = 8'd1 << x_q[2:0];
        bus.io_ram_port_addra = 64'(word_addr);
        bus.io_ram_port_dina  = {8{dens_q}};
        state_d               = StIdle;
      end
      StClear: begin
        bus.io_ram_port_ena   = 1'b1;
        bus.io_ram_port_wea   = 8'hFF;
        bus.io_ram_port_addra = 64'(clr_cnt_q);
        if (clr_cnt_q == CntW'(NUM_WORDS - 1)) begin
          clr_cnt_d       = '0;
          clear_pending_d = 1'b0;
          state_d         = StIdle;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
